pe_slave_arb: RTL
=================

PE_SLAVE_ARB -- requirements
Module: pe_slave_arb

Interface
REQ-001 Param N_MASTER, default 16, number of requesting PE-side masters.
REQ-002 Param ID_WIDTH, default 16, one-hot master ID width; SHALL equal N_MASTER.
REQ-003 Param ADDR_WIDTH, default 32, address width.
REQ-004 Param DATA_WIDTH, default 32, data width; BE_WIDTH = DATA_WIDTH/8.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 data_req_i  in  N_MASTER  per-master request.
REQ-008 data_add_i  in  N_MASTER x ADDR_WIDTH  per-master address.
REQ-009 data_wen_i  in  N_MASTER  per-master write-enable, 1 = read, 0 = write.
REQ-010 data_wdata_i  in  N_MASTER x DATA_WIDTH  per-master write data.
REQ-011 data_be_i  in  N_MASTER x BE_WIDTH  per-master byte enables.
REQ-012 data_ID_i  in  N_MASTER x ID_WIDTH  per-master one-hot ID.
REQ-013 data_gnt_o  out  N_MASTER  per-master grant, at most one bit set.
REQ-014 data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o  out  1/ADDR/1/DATA/BE/ID  forwarded request to peripheral slave.
REQ-015 data_gnt_i  in  1  slave grant.
REQ-016 data_r_valid_i, data_r_ID_i, data_r_rdata_i, data_r_opc_i  in  1/ID/DATA/1  slave response.
REQ-017 data_r_valid_o  out  N_MASTER  one-hot per-master response valid, feeding the per-master response tree.
REQ-018 data_r_rdata_o, data_r_opc_o  out  DATA/1  response payload, broadcast to all masters.

Function
REQ-019 Arbitration SHALL be round-robin: the winner is the first requesting index at or above rr_ptr, wrapping from N_MASTER-1 to 0.
REQ-020 data_req_o SHALL be high in any cycle in which some data_req_i is high; payload and data_ID_o SHALL be the winner's fields, muxed combinationally.
REQ-021 data_gnt_o[w] = data_gnt_i & data_req_o for winner w; all other bits SHALL be 0.
REQ-022 On a handshake (data_req_o & data_gnt_i), rr_ptr SHALL become (w+1) mod N_MASTER on the next edge.
REQ-023 FSM states IDLE and LOCKED: IDLE->LOCKED when data_req_o & !data_gnt_i; LOCKED->IDLE on data_gnt_i; in LOCKED the winner SHALL stay the latched index lock_idx, regardless of other requests.
REQ-024 If lock_idx drops its request while LOCKED, the FSM SHALL return to IDLE next cycle and data_req_o SHALL be 0 for that cycle.
REQ-025 Response path SHALL have 1-cycle latency: data_r_valid_o <= data_r_ID_i when data_r_valid_i, else all zero; rdata and opc SHALL be registered on data_r_valid_i only.
REQ-026 A response and a new request in the same cycle SHALL be handled independently with no stall.
REQ-027 A data_r_ID_i that is not one-hot SHALL be forwarded unchanged; this is a simulation assertion error.
REQ-028 No internal request buffering: the slave sees at most the current winner; ordering is the slave's responsibility.

Reset
REQ-029 With rst_n low at an edge: rr_ptr=0, FSM=IDLE, lock_idx=0, data_r_valid_o=0, data_r_rdata_o=0, data_r_opc_o=0.
REQ-030 Reset asserted mid-LOCKED SHALL drop the lock; reset asserted with a response in flight SHALL discard it, with no valid out the next cycle.

Structure
REQ-031 Shared package pe_interco_pkg SHALL hold the FSM state enum and the BE_WIDTH derivation function.
REQ-032 Round-robin priority selection SHALL be one sub-module, pe_rr_select (inputs: req vector, pointer; outputs: winner index, any-valid).

Verification
REQ-033 Reset, all inputs idle -> all outputs 0 and rr_ptr=0 on the first post-reset cycle.
REQ-034 Masters 0, 3, 5 request with gnt_i=1 every cycle -> grants in order 0,3,5,0; data_ID_o tracks each winner's ID.
REQ-035 Master 2 requests with gnt_i=0 for 3 cycles, and master 1 raises its request in cycle 2 -> data_ID_o stays master 2 until gnt_i=1, then master 1 wins next.
REQ-036 Master 4 drops its request while LOCKED -> data_req_o=0 the next cycle and FSM=IDLE.
REQ-037 data_r_valid_i=1, ID=16'h0040, rdata=32'hDEADBEEF -> next cycle data_r_valid_o=16'h0040, rdata=32'hDEADBEEF; the following cycle valid_o=0.
REQ-038 rst_n low while LOCKED with a response pending -> next cycle FSM=IDLE, data_r_valid_o=0, and the next arbitration starts at index 0.

Source files
------------

// File: rtl/pe_interco_pkg.sv
// Shared types and helpers for the PE-side slave arbiter.
package pe_interco_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pe_rr_select.sv
// Round-robin priority pick: first requesting index at or above ptr, wrapping.
module pe_rr_select #(
  parameter  int N  = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int            k;
  logic [IW-1:0] kk;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    kk    = '0;
    for (int off = N - 1; off >= 0; off--) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      kk = IW'(k);
      if (req[kk]) begin
        valid = 1'b1;
        idx   = kk;
      end
    end
  end

endmodule

// File: rtl/pe_slave_arb.sv
// Round-robin arbiter from N PE-side masters onto one peripheral slave port,
// with a 1-cycle registered response fan-back.
module pe_slave_arb
  import pe_interco_pkg::*;
#(
  parameter  int N_MASTER   = 16,
  parameter  int ID_WIDTH   = 16,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int BE_WIDTH   = be_width(DATA_WIDTH),
  localparam int IW         = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTER-1:0]                  data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
  input  logic [N_MASTER-1:0]                  data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
  input  logic [N_MASTER-1:0][ID_WIDTH-1:0]    data_ID_i,
  output logic [N_MASTER-1:0]                  data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_r_valid_i,
  input  logic [ID_WIDTH-1:0]                  data_r_ID_i,
  input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
  input  logic                                 data_r_opc_i,
  output logic [N_MASTER-1:0]                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_r_opc_o,
  output arb_state_t                           state,
  output logic [IW-1:0]                        rr_ptr,
  output logic [IW-1:0]                        lock_idx
);

  // Handshake: a request is accepted in any cycle where data_req_o & data_gnt_i;
  // until then the winner is held (LOCKED) so the slave sees a stable request.

  logic [IW-1:0] sel_idx;
  logic          any_req;
  logic [IW-1:0] winner;
  logic [IW-1:0] ptr_next;

  pe_rr_select #(.N(N_MASTER)) u_rr_select (
    .req   (data_req_i),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .valid (any_req)
  );

  assign winner   = (state == ST_LOCKED) ? lock_idx : sel_idx;
  assign ptr_next = (winner == IW'(N_MASTER - 1)) ? '0 : winner + IW'(1);

  // A locked master that withdraws gets no forwarded request, even if others wait.
  assign data_req_o   = (state == ST_LOCKED) ? data_req_i[lock_idx] : any_req;
  assign data_add_o   = data_add_i[winner];
  assign data_wen_o   = data_wen_i[winner];
  assign data_wdata_o = data_wdata_i[winner];
  assign data_be_o    = data_be_i[winner];
  assign data_ID_o    = data_ID_i[winner];

  always_comb begin
    data_gnt_o         = '0;
    data_gnt_o[winner] = data_gnt_i & data_req_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            if (data_gnt_i) begin
              rr_ptr <= ptr_next;
            end else begin
              state    <= ST_LOCKED;
              lock_idx <= sel_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (!data_req_i[lock_idx]) begin
            state <= ST_IDLE;
          end else if (data_gnt_i) begin
            state  <= ST_IDLE;
            rr_ptr <= ptr_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r_valid_o <= '0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
    end else begin
      data_r_valid_o <= data_r_valid_i ? data_r_ID_i : '0;
      if (data_r_valid_i) begin
        data_r_rdata_o <= data_r_rdata_i;
        data_r_opc_o   <= data_r_opc_i;
      end
    end
  end

  // A malformed response ID is still forwarded; flag it in simulation only.
  always @(posedge clk) begin
    if (rst_n && data_r_valid_i)
      assert ($onehot(data_r_ID_i))
      else $error("pe_slave_arb: response ID %h is not one-hot", data_r_ID_i);
  end

endmodule
